// File: rtl/mono_mode_sequencer_pkg.sv
// mono_mode_sequencer_pkg: mode codes, FSM states and request sources shared by the mode sequencer
package mono_mode_sequencer_pkg;
    localparam logic [1:0] MODE_COLOR = 2'b00;
    localparam logic [1:0] MODE_GREEN = 2'b01;
    localparam logic [1:0] MODE_AMBER = 2'b10;
    localparam logic [1:0] MODE_GREY  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    typedef enum logic {
        SRC_CPU = 1'b0,
        SRC_KEY = 1'b1
    } src_e;
endpackage

// File: rtl/mono_mode_sequencer_if.sv
// mono_mode_sequencer_if: request strobes from hotkey/CPU and mode/status outputs of the sequencer
interface mono_mode_sequencer_if;
    logic       key_stb;
    logic       io_we;
    logic [1:0] io_wdata;
    logic [1:0] mode;
    logic [1:0] io_rdata;
    logic       pending;
    logic       holdoff;

    modport master (output key_stb, io_we, io_wdata, input mode, io_rdata, pending, holdoff);
    modport slave  (input key_stb, io_we, io_wdata, output mode, io_rdata, pending, holdoff);
endinterface

// File: rtl/vsync_edge_sync.sv
// vsync_edge_sync: two-flop synchroniser plus edge flop, registered one-cycle pulse on inactive->active sync transition
module vsync_edge_sync #(
    parameter bit POL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_in,
    output logic start
);
    logic [2:0] sh_q, sh_d;
    logic       start_q, start_d;

    // shift the raw pin through the synchroniser and flag a fresh active level
    always_comb begin
        sh_d    = {sh_q[1:0], sync_in};
        start_d = (sh_q[1] == POL) && (sh_q[2] != POL);
    end

    // sync flops come out of reset at the inactive level so reset never fakes an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q    <= {3{~POL}};
            start_q <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            start_q <= start_d;
        end
    end

    assign start = start_q;
endmodule

// File: rtl/mono_mode_sequencer.sv
// mono_mode_sequencer: defers monochrome mode changes to vertical-sync start, with hotkey holdoff and VSYNC-loss fallback
module mono_mode_sequencer
    import mono_mode_sequencer_pkg::*;
#(
    parameter bit VSYNC_POL      = 1'b0,
    parameter int HOLDOFF_FRAMES = 8,
    parameter int VS_TIMEOUT     = 2000000
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    input  logic                 VSYNC,
    mono_mode_sequencer_if.slave bus
);
    localparam int TW = $clog2(VS_TIMEOUT);

    state_e        state_q, state_d;
    src_e          src_q, src_d;
    logic [1:0]    mode_q, mode_d, tgt_q, tgt_d, key_next;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    frm_q, frm_d;
    logic          vs_start, tmo_hit, apply;

    vsync_edge_sync #(.POL(VSYNC_POL)) u_vs (
        .clk     (CLK),
        .rst_n   (RST_n),
        .sync_in (VSYNC),
        .start   (vs_start)
    );

    // next-state: CPU beats hotkey, new requests beat applying, timeout stands in for a missing vsync
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        mode_d   = mode_q;
        tgt_d    = tgt_q;
        tmo_d    = '0;
        frm_d    = '0;
        key_next = ((state_q == ST_PEND) ? tgt_q : mode_q) + 2'd1;
        tmo_hit  = tmo_q == TW'(VS_TIMEOUT - 1);
        apply    = vs_start || tmo_hit;
        case (state_q)
            ST_IDLE: begin
                if (bus.io_we) begin
                    tgt_d   = bus.io_wdata;
                    src_d   = SRC_CPU;
                    state_d = ST_PEND;
                end else if (bus.key_stb) begin
                    tgt_d   = key_next;
                    src_d   = SRC_KEY;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                tmo_d = apply ? '0 : tmo_q + TW'(1);
                if (bus.io_we) begin
                    tgt_d = bus.io_wdata;
                    src_d = SRC_CPU;
                end else if (bus.key_stb) begin
                    tgt_d = key_next;
                    src_d = SRC_KEY;
                end else if (apply) begin
                    mode_d  = tgt_q;
                    state_d = (src_q == SRC_KEY) ? ST_HOLD : ST_IDLE;
                    frm_d   = (src_q == SRC_KEY) ? 8'(HOLDOFF_FRAMES) : 8'd0;
                end
            end
            ST_HOLD: begin
                tmo_d = apply ? '0 : tmo_q + TW'(1);
                frm_d = (vs_start && frm_q != 8'd0) ? frm_q - 8'd1 : frm_q;
                if (bus.io_we) begin
                    tgt_d   = bus.io_wdata;
                    src_d   = SRC_CPU;
                    state_d = ST_PEND;
                    tmo_d   = '0;
                    frm_d   = '0;
                end else if (tmo_hit || (vs_start && frm_q <= 8'd1)) begin
                    state_d = ST_IDLE;
                    frm_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state, target and counter registers; reset drops any pending request
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= ST_IDLE;
            src_q   <= SRC_CPU;
            mode_q  <= MODE_COLOR;
            tgt_q   <= MODE_COLOR;
            tmo_q   <= '0;
            frm_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            mode_q  <= mode_d;
            tgt_q   <= tgt_d;
            tmo_q   <= tmo_d;
            frm_q   <= frm_d;
        end
    end

    assign bus.mode     = mode_q;
    assign bus.io_rdata = (state_q == ST_PEND) ? tgt_q : mode_q;
    assign bus.pending  = state_q == ST_PEND;
    assign bus.holdoff  = state_q == ST_HOLD;
endmodule

// File: tb/tb_mono_mode_sequencer.sv
// tb_mono_mode_sequencer: scoreboard-driven scenarios for the vsync-deferred mode sequencer
module tb_mono_mode_sequencer;
    import mono_mode_sequencer_pkg::*;

    logic       CLK     = 1'b0;
    logic       RST_n   = 1'b1;
    logic       VSYNC   = 1'b1;
    logic       VSYNC_T = 1'b1;
    int         checks   = 0;
    int         failures = 0;
    logic [1:0] exp_q[$];
    logic [1:0] e;

    mono_mode_sequencer_if bus();
    mono_mode_sequencer_if bus_t();

    always #5 CLK = ~CLK;

    mono_mode_sequencer #(.VSYNC_POL(1'b0), .HOLDOFF_FRAMES(8), .VS_TIMEOUT(1024)) dut (
        .CLK(CLK), .RST_n(RST_n), .VSYNC(VSYNC), .bus(bus)
    );

    mono_mode_sequencer #(.VSYNC_POL(1'b0), .HOLDOFF_FRAMES(8), .VS_TIMEOUT(64)) dut_t (
        .CLK(CLK), .RST_n(RST_n), .VSYNC(VSYNC_T), .bus(bus_t)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset;
        bus.key_stb = 1'b0; bus.io_we = 1'b0; bus.io_wdata = 2'b00; VSYNC = 1'b1;
        #2 RST_n = 1'b0;
        tick(2);
        RST_n = 1'b1;
        tick(1);
    endtask

    task automatic vsync_pulse;
        VSYNC = 1'b0;
        tick(4);
        VSYNC = 1'b1;
        tick(6);
    endtask

    task automatic test_reset;
        bus.key_stb = 1'b0; bus.io_we = 1'b0; bus.io_wdata = 2'b00;
        bus_t.key_stb = 1'b0; bus_t.io_we = 1'b0; bus_t.io_wdata = 2'b00;
        #2 RST_n = 1'b0;
        tick(2);
        checks++; if (bus.mode !== MODE_COLOR) begin failures++; $display("FAIL rst_mode got=%b exp=%b", bus.mode, MODE_COLOR); end
        checks++; if (bus.io_rdata !== 2'b00) begin failures++; $display("FAIL rst_rdata got=%b exp=00", bus.io_rdata); end
        checks++; if (bus.pending !== 1'b0) begin failures++; $display("FAIL rst_pending got=%b exp=0", bus.pending); end
        checks++; if (bus.holdoff !== 1'b0) begin failures++; $display("FAIL rst_holdoff got=%b exp=0", bus.holdoff); end
        checks++; if (bus_t.mode !== MODE_COLOR) begin failures++; $display("FAIL rst_mode_t got=%b exp=00", bus_t.mode); end
        RST_n = 1'b1;
        tick(1);
    endtask

    task automatic test_single_key;
        int bad = 0;
        bus.key_stb = 1'b1;
        tick(1);
        bus.key_stb = 1'b0;
        exp_q.push_back(MODE_GREEN);
        checks++; if (bus.pending !== 1'b1) begin failures++; $display("FAIL t1_pending got=%b exp=1", bus.pending); end
        checks++; if (bus.io_rdata !== MODE_GREEN) begin failures++; $display("FAIL t1_rdata got=%b exp=%b", bus.io_rdata, MODE_GREEN); end
        for (int i = 0; i < 500; i++) begin
            if (bus.pending !== 1'b1 || bus.mode !== MODE_COLOR) bad++;
            tick(1);
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL t1_wait bad_cycles=%0d exp=0", bad); end
        VSYNC = 1'b0;
        tick(3);
        checks++; if (bus.mode !== MODE_COLOR || bus.pending !== 1'b1) begin failures++; $display("FAIL t1_early mode=%b pending=%b exp=00/1", bus.mode, bus.pending); end
        tick(1);
        e = exp_q.pop_front();
        checks++; if (bus.mode !== e) begin failures++; $display("FAIL t1_mode got=%b exp=%b", bus.mode, e); end
        checks++; if (bus.holdoff !== 1'b1 || bus.pending !== 1'b0) begin failures++; $display("FAIL t1_flags holdoff=%b pending=%b exp=1/0", bus.holdoff, bus.pending); end
        VSYNC = 1'b1;
        tick(6);
    endtask

    task automatic test_key_accumulate;
        do_reset();
        bus.key_stb = 1'b1;
        tick(3);
        bus.key_stb = 1'b0;
        exp_q.push_back(MODE_GREY);
        checks++; if (bus.io_rdata !== MODE_GREY) begin failures++; $display("FAIL t2_tgt got=%b exp=%b", bus.io_rdata, MODE_GREY); end
        vsync_pulse();
        e = exp_q.pop_front();
        checks++; if (bus.mode !== e) begin failures++; $display("FAIL t2_mode got=%b exp=%b", bus.mode, e); end
        checks++; if (bus.holdoff !== 1'b1) begin failures++; $display("FAIL t2_holdoff got=%b exp=1", bus.holdoff); end
        for (int f = 1; f <= 8; f++) begin
            bus.key_stb = 1'b1;
            tick(1);
            bus.key_stb = 1'b0;
            vsync_pulse();
            checks++; if (bus.mode !== MODE_GREY) begin failures++; $display("FAIL t2_hold_mode frame=%0d got=%b exp=%b", f, bus.mode, MODE_GREY); end
            checks++; if (bus.holdoff !== (f < 8)) begin failures++; $display("FAIL t2_hold_flag frame=%0d got=%b exp=%b", f, bus.holdoff, (f < 8)); end
        end
        checks++; if (bus.pending !== 1'b0) begin failures++; $display("FAIL t2_pending got=%b exp=0", bus.pending); end
    endtask

    task automatic test_cpu_wins;
        do_reset();
        bus.io_we = 1'b1; bus.io_wdata = MODE_AMBER; bus.key_stb = 1'b1;
        tick(1);
        bus.io_we = 1'b0; bus.key_stb = 1'b0;
        exp_q.push_back(MODE_AMBER);
        checks++; if (bus.pending !== 1'b1 || bus.io_rdata !== MODE_AMBER) begin failures++; $display("FAIL t3_req pending=%b rdata=%b exp=1/%b", bus.pending, bus.io_rdata, MODE_AMBER); end
        vsync_pulse();
        e = exp_q.pop_front();
        checks++; if (bus.mode !== e) begin failures++; $display("FAIL t3_mode got=%b exp=%b", bus.mode, e); end
        checks++; if (bus.holdoff !== 1'b0 || bus.pending !== 1'b0) begin failures++; $display("FAIL t3_idle holdoff=%b pending=%b exp=0/0", bus.holdoff, bus.pending); end
    endtask

    task automatic test_timeout;
        int bad = 0;
        bus_t.io_we = 1'b1; bus_t.io_wdata = MODE_GREY;
        tick(1);
        bus_t.io_we = 1'b0;
        exp_q.push_back(MODE_GREY);
        for (int k = 0; k < 64; k++) begin
            if (bus_t.mode !== MODE_COLOR || bus_t.io_rdata !== MODE_GREY || bus_t.pending !== 1'b1) bad++;
            tick(1);
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL t4_wait bad_cycles=%0d exp=0", bad); end
        e = exp_q.pop_front();
        checks++; if (bus_t.mode !== e) begin failures++; $display("FAIL t4_mode got=%b exp=%b", bus_t.mode, e); end
        checks++; if (bus_t.io_rdata !== MODE_GREY || bus_t.pending !== 1'b0) begin failures++; $display("FAIL t4_after rdata=%b pending=%b exp=%b/0", bus_t.io_rdata, bus_t.pending, MODE_GREY); end
    endtask

    task automatic test_vs_collision;
        do_reset();
        VSYNC = 1'b0;
        tick(3);
        bus.io_we = 1'b1; bus.io_wdata = MODE_GREEN;
        tick(1);
        bus.io_we = 1'b0;
        exp_q.push_back(MODE_GREEN);
        checks++; if (bus.mode !== MODE_COLOR || bus.pending !== 1'b1) begin failures++; $display("FAIL t5_idle_hit mode=%b pending=%b exp=00/1", bus.mode, bus.pending); end
        VSYNC = 1'b1;
        tick(6);
        checks++; if (bus.mode !== MODE_COLOR) begin failures++; $display("FAIL t5_deferred got=%b exp=00", bus.mode); end
        vsync_pulse();
        e = exp_q.pop_front();
        checks++; if (bus.mode !== e) begin failures++; $display("FAIL t5_mode got=%b exp=%b", bus.mode, e); end
        bus.io_we = 1'b1; bus.io_wdata = MODE_AMBER;
        tick(1);
        bus.io_we = 1'b0;
        VSYNC = 1'b0;
        tick(3);
        bus.io_we = 1'b1; bus.io_wdata = MODE_GREY;
        tick(1);
        bus.io_we = 1'b0;
        exp_q.push_back(MODE_GREY);
        checks++; if (bus.mode !== MODE_GREEN || bus.io_rdata !== MODE_GREY || bus.pending !== 1'b1) begin failures++; $display("FAIL t5_pend_hit mode=%b rdata=%b pending=%b exp=01/11/1", bus.mode, bus.io_rdata, bus.pending); end
        VSYNC = 1'b1;
        tick(6);
        vsync_pulse();
        e = exp_q.pop_front();
        checks++; if (bus.mode !== e) begin failures++; $display("FAIL t5_mode2 got=%b exp=%b", bus.mode, e); end
    endtask

    task automatic test_async_reset;
        do_reset();
        bus.io_we = 1'b1; bus.io_wdata = MODE_AMBER;
        tick(1);
        bus.io_we = 1'b0;
        exp_q.push_back(MODE_AMBER);
        vsync_pulse();
        e = exp_q.pop_front();
        checks++; if (bus.mode !== e) begin failures++; $display("FAIL t6_pre got=%b exp=%b", bus.mode, e); end
        bus.io_we = 1'b1; bus.io_wdata = MODE_GREEN;
        tick(1);
        bus.io_we = 1'b0;
        checks++; if (bus.pending !== 1'b1) begin failures++; $display("FAIL t6_pend got=%b exp=1", bus.pending); end
        exp_q.push_back(MODE_COLOR);
        #3 RST_n = 1'b0;
        #1;
        e = exp_q.pop_front();
        checks++; if (bus.mode !== e) begin failures++; $display("FAIL t6_rst_mode got=%b exp=%b", bus.mode, e); end
        checks++; if (bus.pending !== 1'b0 || bus.io_rdata !== 2'b00) begin failures++; $display("FAIL t6_rst_flags pending=%b rdata=%b exp=0/00", bus.pending, bus.io_rdata); end
        tick(2);
        RST_n = 1'b1;
        tick(1);
        vsync_pulse();
        checks++; if (bus.mode !== MODE_COLOR || bus.pending !== 1'b0) begin failures++; $display("FAIL t6_after mode=%b pending=%b exp=00/0", bus.mode, bus.pending); end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_key_accumulate();
        test_cpu_wins();
        test_timeout();
        test_vs_collision();
        test_async_reset();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
